// File: rtl/decode_execute_register_if.sv
// Decode-to-Execute bundle: decoded controls and operands in, registered copies out.
interface decode_execute_register_if;
    logic        stall;
    logic        flush;
    logic        wbs_in;
    logic        mm_in;
    logic [2:0]  ALUop_in;
    logic        wm_in;
    logic        am_in;
    logic        ni_in;
    logic        wme_in;
    logic        wme1_in;
    logic [15:0] srcA_in;
    logic [15:0] srcB_in;
    logic        wbs_out;
    logic        mm_out;
    logic [2:0]  ALUop_out;
    logic        wm_out;
    logic        am_out;
    logic        ni_out;
    logic        wme_out;
    logic        wme1_out;
    logic [15:0] srcA_out;
    logic [15:0] srcB_out;

    // Decode stage / hazard unit side
    modport master (
        output stall, flush,
        output wbs_in, mm_in, ALUop_in, wm_in, am_in, ni_in, wme_in, wme1_in, srcA_in, srcB_in,
        input  wbs_out, mm_out, ALUop_out, wm_out, am_out, ni_out, wme_out, wme1_out,
        input  srcA_out, srcB_out
    );

    // Pipeline register side
    modport slave (
        input  stall, flush,
        input  wbs_in, mm_in, ALUop_in, wm_in, am_in, ni_in, wme_in, wme1_in, srcA_in, srcB_in,
        output wbs_out, mm_out, ALUop_out, wm_out, am_out, ni_out, wme_out, wme1_out,
        output srcA_out, srcB_out
    );
endinterface

// File: rtl/decode_execute_register.sv
// Decode/Execute pipeline register: one-cycle capture with stall (hold) and flush (bubble).
module decode_execute_register (
    input  logic                           clk,
    input  logic                           rst_n,
    decode_execute_register_if.slave       de_if
);

    typedef struct packed {
        logic        wbs;
        logic        mm;
        logic [2:0]  alu_op;
        logic        wm;
        logic        am;
        logic        ni;
        logic        wme;
        logic        wme1;
        logic [15:0] src_a;
        logic [15:0] src_b;
    } de_fields_t;

    de_fields_t fields_d;
    de_fields_t fields_q;
    de_fields_t fields_in;

    always_comb begin
        fields_in.wbs    = de_if.wbs_in;
        fields_in.mm     = de_if.mm_in;
        fields_in.alu_op = de_if.ALUop_in;
        fields_in.wm     = de_if.wm_in;
        fields_in.am     = de_if.am_in;
        fields_in.ni     = de_if.ni_in;
        fields_in.wme    = de_if.wme_in;
        fields_in.wme1   = de_if.wme1_in;
        fields_in.src_a  = de_if.srcA_in;
        fields_in.src_b  = de_if.srcB_in;
    end

    // Flush wins over stall so a bubble can be injected into a stalled stage.
    always_comb begin
        fields_d = fields_q;
        if (de_if.flush) begin
            fields_d = '0;
        end else if (!de_if.stall) begin
            fields_d = fields_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign de_if.wbs_out   = fields_q.wbs;
    assign de_if.mm_out    = fields_q.mm;
    assign de_if.ALUop_out = fields_q.alu_op;
    assign de_if.wm_out    = fields_q.wm;
    assign de_if.am_out    = fields_q.am;
    assign de_if.ni_out    = fields_q.ni;
    assign de_if.wme_out   = fields_q.wme;
    assign de_if.wme1_out  = fields_q.wme1;
    assign de_if.srcA_out  = fields_q.src_a;
    assign de_if.srcB_out  = fields_q.src_b;

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for decode_execute_register: reset, capture, stall, flush, async reset.
module tb_decode_execute_register;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    decode_execute_register_if bus ();

    decode_execute_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .de_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wbs, mm, ALUop[2:0], wm, am, ni, wme, wme1, srcA[15:0], srcB[15:0]}
    function automatic logic [41:0] pack(input logic wbs, input logic mm, input logic [2:0] op,
                                         input logic wm, input logic am, input logic ni,
                                         input logic wme, input logic wme1,
                                         input logic [15:0] a, input logic [15:0] b);
        return {wbs, mm, op, wm, am, ni, wme, wme1, a, b};
    endfunction

    task automatic drive(input logic [41:0] v);
        {bus.wbs_in, bus.mm_in, bus.ALUop_in, bus.wm_in, bus.am_in, bus.ni_in,
         bus.wme_in, bus.wme1_in, bus.srcA_in, bus.srcB_in} = v;
    endtask

    task automatic check(input string tag, input logic [41:0] exp);
        logic [41:0] obs;
        obs = {bus.wbs_out, bus.mm_out, bus.ALUop_out, bus.wm_out, bus.am_out, bus.ni_out,
               bus.wme_out, bus.wme1_out, bus.srcA_out, bus.srcB_out};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [41:0] v_rst, v_cap1, v_cap2, v_stall_in, v_stall_out, v_cap3, v_cap4;

    initial begin
        n_total = 0;
        n_pass  = 0;
        v_rst       = pack(1'b1, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hABCD);
        v_cap1      = pack(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 16'h0007);
        v_cap2      = pack(1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0005);
        v_stall_in  = pack(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0005);
        v_stall_out = 42'h0_0000_0000_0 | {2'b00, 3'b111, 5'b00000, 16'hFFFF, 16'h0005};
        v_cap3      = pack(1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h0001);
        v_cap4      = pack(1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFE, 16'hFFFE);

        // Reset with nonzero inputs
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(v_rst);
        #3;
        check("reset_immediate", 42'h0);
        edge_step();
        edge_step();
        check("reset_held_over_edges", 42'h0);
        rst_n = 1'b1;
        #2;
        check("reset_release_no_edge", 42'h0);
        edge_step();
        check("first_capture_after_reset", v_rst);

        // Capture 1 and 2
        drive(v_cap1);
        edge_step();
        check("capture1", v_cap1);
        drive(v_cap2);
        #3;
        check("capture2_before_edge", v_cap1);
        edge_step();
        check("capture2", v_cap2);

        // Stall for three edges while inputs change
        bus.stall = 1'b1;
        drive(v_stall_in);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check($sformatf("stall_hold_%0d", i), v_cap2);
        end
        bus.stall = 1'b0;
        edge_step();
        check("stall_release_capture", v_stall_out);

        // Distinct control patterns to separate individual fields
        drive(v_cap3);
        edge_step();
        check("capture3", v_cap3);
        drive(v_cap4);
        edge_step();
        check("capture4", v_cap4);

        // Flush overrides stall
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(v_cap1);
        edge_step();
        check("flush_with_stall", 42'h0);
        bus.flush = 1'b0;
        edge_step();
        check("stall_after_flush_holds_bubble", 42'h0);
        bus.stall = 1'b0;
        edge_step();
        check("capture_after_flush", v_cap1);

        // Flush alone
        bus.flush = 1'b1;
        drive(v_cap4);
        edge_step();
        check("flush_alone", 42'h0);
        bus.flush = 1'b0;
        edge_step();
        check("capture_after_flush_alone", v_cap4);

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", 42'h0);
        rst_n = 1'b1;
        #1;
        check("async_reset_released_before_edge", 42'h0);
        drive(v_cap3);
        edge_step();
        check("capture_after_async_reset", v_cap3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_execute_register.md
# decode_execute_register

Pipeline register between the Decode and Execute stages of the 16-bit pipelined CPU. On each rising clock edge it captures the decoded control bits (write-back select, memory-access controls, ALU operation, write/accumulate/next-instruction flags) and the two 16-bit source operands, and presents them to the Execute stage for one full cycle. It supports a stall, which holds the current contents, and a flush, which inserts a bubble, for hazard handling.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all capture happens on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- stall  input  1  when high, hold all outputs unchanged.
- flush  input  1  when high, load a bubble (all outputs zero).
- wbs_in  input  1  write-back source select.
- mm_in  input  1  memory-to-register (memory mux) select.
- ALUop_in  input  3  ALU operation code.
- wm_in  input  1  write-memory enable.
- am_in  input  1  ALU-operand mux select.
- ni_in  input  1  next-instruction / branch flag.
- wme_in  input  1  write-memory-enable, stage 0 copy.
- wme1_in  input  1  write-memory-enable, stage 1 copy.
- srcA_in  input  16  source operand A.
- srcB_in  input  16  source operand B.
- wbs_out, mm_out, wm_out, am_out, ni_out, wme_out, wme1_out  output  1 each  registered copies of the matching inputs.
- ALUop_out  output  3  registered ALUop_in.
- srcA_out, srcB_out  output  16 each  registered operands.

## Operation
- Every output is driven directly from a flip-flop. No combinational path exists from any input to any output.
- Priority at each rising edge of clk, with rst_n high:
  - flush=1: all outputs become 0. This is a NOP bubble, and flush overrides stall.
- flush=0 and stall=1: all outputs keep their previous values.
- flush=0 and stall=0: each *_out takes the value of its *_in.
- rst_n low: all outputs go to 0 immediately, without waiting for a clock edge. They stay 0 while rst_n is low.
- Operands pass through bit-exact. No sign extension, arithmetic or width change.
- The control fields are treated as opaque bits and are not decoded inside this block.
- All fields update together. A partial update of only some fields is never allowed.

## Timing
- Latency is 1 cycle: a value present at the inputs just before rising edge N appears at the outputs just after edge N. It is held until edge N+1.
- Inputs must be stable across the setup/hold window around the rising edge. Changes between edges have no effect on the outputs.
- Reset assertion is asynchronous. Reset release is treated as synchronous by downstream logic: the first capture happens on the first rising edge after rst_n goes high.
- Reset that arrives mid-operation discards the held contents. No state survives reset.
- flush and stall are sampled at the same edge as the data.
- If stall stays high for several cycles, the outputs hold for those cycles. Once stall drops, the next edge captures the current inputs.
- Value of every output after reset: 0 (ALUop_out=3'b000, srcA_out=srcB_out=16'h0000).

## Test plan
- Reset: drive rst_n=0 with nonzero inputs -> all outputs read 0 immediately and across clock edges. Release rst_n -> the first edge captures the inputs.
- Capture 1: wbs/mm/wm/am/ni=1, wme=0, wme1=0, ALUop=001, srcA=16'h0006, srcB=16'h0007, then one edge -> outputs equal exactly those values.
- Capture 2: next cycle apply all controls=0, ALUop=010, srcA=16'h0001, srcB=16'h0005 -> after one edge the outputs equal those values. Before that edge, the previous values are still held.
- Stall: stall=1 while the inputs change to srcA=16'hFFFF and ALUop=111 for 3 edges -> outputs keep their pre-stall values. Drop stall -> the next edge loads 16'hFFFF / 111.
- Flush: flush=1 together with stall=1 and nonzero inputs -> after the edge all outputs are 0. Clear flush -> normal capture resumes.
- Async reset mid-stream: pulse rst_n low between clock edges while the outputs are nonzero -> outputs go to 0 before the next edge.
